// File: rtl/mem_access_arbiter_if.sv
// Bus bundle between the two memory requesters, the arbiter and the data memory.
// Slave modport is the arbiter's view; master is the requester/memory side.
interface mem_access_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 128
);
    logic              reqA;
    logic              reqB;
    logic              weA;
    logic              weB;
    logic [ADDR_W-1:0] addrA;
    logic [ADDR_W-1:0] addrB;
    logic [31:0]       wdataA;
    logic [31:0]       wdataB;
    logic              doneA;
    logic              doneB;
    logic              errA;
    logic              errB;
    logic [LINE_W-1:0] rdata;
    logic [ADDR_W-1:0] memAddress;
    logic [31:0]       memInputData;
    logic              memWriteMem;
    logic [LINE_W-1:0] memData;
    logic              busy;

    modport slave (
        input  reqA, reqB, weA, weB, addrA, addrB, wdataA, wdataB, memData,
        output doneA, doneB, errA, errB, rdata, memAddress, memInputData,
               memWriteMem, busy
    );

    modport master (
        output reqA, reqB, weA, weB, addrA, addrB, wdataA, wdataB, memData,
        input  doneA, doneB, errA, errB, rdata, memAddress, memInputData,
               memWriteMem, busy
    );
endinterface

// File: rtl/mem_access_arbiter.sv
// Round-robin sharing of the data memory between fetch port A and load/store port B:
// fixed-latency line reads, single-word writes, out-of-range accesses rejected.
module mem_access_arbiter #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned LINE_W    = 128,
    parameter int unsigned READ_LAT  = 4,
    parameter int unsigned MEM_BYTES = 1024
) (
    input logic                 CLk,
    input logic                 resetN,
    mem_access_arbiter_if.slave bus
);
    localparam int unsigned CNT_W  = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam int unsigned WORD_W = 32;

    localparam logic [ADDR_W-1:0] RD_MASK  = ~ADDR_W'(15);
    localparam logic [ADDR_W-1:0] WR_MASK  = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] RD_LIMIT = ADDR_W'(MEM_BYTES - 16);
    localparam logic [ADDR_W-1:0] WR_LIMIT = ADDR_W'(MEM_BYTES - 4);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(READ_LAT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR      = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t              state;
    logic                ptr_b;
    logic                owner_b;
    logic [CNT_W-1:0]    cnt;
    logic                done_a;
    logic                done_b;
    logic                err_a;
    logic                err_b;
    logic [LINE_W-1:0]   rdata_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [WORD_W-1:0]   mem_wdata_q;
    logic                mem_we_q;
    logic                busy_q;

    logic                grant_b_c;
    logic                sel_we_c;
    logic [ADDR_W-1:0]   sel_addr_c;
    logic [WORD_W-1:0]   sel_wdata_c;
    logic [ADDR_W-1:0]   aligned_c;
    logic                legal_c;

    // Winner selection and range check for the request seen in IDLE
    always_comb begin
        grant_b_c   = 1'b0;
        sel_we_c    = 1'b0;
        sel_addr_c  = '0;
        sel_wdata_c = '0;
        aligned_c   = '0;
        legal_c     = 1'b0;

        grant_b_c   = bus.reqB & (~bus.reqA | ptr_b);
        sel_we_c    = grant_b_c ? bus.weB    : bus.weA;
        sel_addr_c  = grant_b_c ? bus.addrB  : bus.addrA;
        sel_wdata_c = grant_b_c ? bus.wdataB : bus.wdataA;

        if (sel_we_c) begin
            aligned_c = sel_addr_c & WR_MASK;
            legal_c   = (aligned_c <= WR_LIMIT);
        end else begin
            aligned_c = sel_addr_c & RD_MASK;
            legal_c   = (aligned_c <= RD_LIMIT);
        end
    end

    // Sequencer; done/err are only ever set on the edge that enters DONE
    always_ff @(posedge CLk or negedge resetN) begin
        if (!resetN) begin
            state       <= IDLE;
            ptr_b       <= 1'b0;
            owner_b     <= 1'b0;
            cnt         <= '0;
            done_a      <= 1'b0;
            done_b      <= 1'b0;
            err_a       <= 1'b0;
            err_b       <= 1'b0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            done_a <= 1'b0;
            done_b <= 1'b0;
            err_a  <= 1'b0;
            err_b  <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.reqA || bus.reqB) begin
                        ptr_b   <= ~grant_b_c;
                        owner_b <= grant_b_c;
                        busy_q  <= 1'b1;
                        if (!legal_c) begin
                            state  <= DONE;
                            done_a <= ~grant_b_c;
                            done_b <= grant_b_c;
                            err_a  <= ~grant_b_c;
                            err_b  <= grant_b_c;
                        end else if (sel_we_c) begin
                            state       <= WR;
                            mem_addr_q  <= aligned_c;
                            mem_wdata_q <= sel_wdata_c;
                            mem_we_q    <= 1'b1;
                        end else begin
                            state      <= RD_WAIT;
                            mem_addr_q <= aligned_c;
                            cnt        <= CNT_LOAD;
                        end
                    end
                end

                RD_WAIT: begin
                    if (cnt == '0) begin
                        rdata_q <= bus.memData;
                        state   <= DONE;
                        done_a  <= ~owner_b;
                        done_b  <= owner_b;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                WR: begin
                    mem_we_q <= 1'b0;
                    state    <= DONE;
                    done_a   <= ~owner_b;
                    done_b   <= owner_b;
                end

                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end

                default: begin
                    state    <= IDLE;
                    mem_we_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.doneA        = done_a;
    assign bus.doneB        = done_b;
    assign bus.errA         = err_a;
    assign bus.errB         = err_b;
    assign bus.rdata        = rdata_q;
    assign bus.memAddress   = mem_addr_q;
    assign bus.memInputData = mem_wdata_q;
    assign bus.memWriteMem  = mem_we_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter: byte memory model with fixed read latency,
// a table of single-port transactions, and hand sequences for contention and reset.
module tb_mem_access_arbiter;
    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned LINE_W    = 128;
    localparam int unsigned READ_LAT  = 4;
    localparam int unsigned MEM_BYTES = 1024;
    localparam int          NV        = 14;

    typedef struct {
        bit          pb;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          exp_err;
        logic [31:0] exp_maddr;
        int          exp_lat;
        int          exp_wr;
        logic [31:0] exp_w0;
        logic [31:0] exp_w3;
    } vec_t;

    logic clk;
    logic resetN;

    mem_access_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

    mem_access_arbiter #(
        .ADDR_W   (ADDR_W),
        .LINE_W   (LINE_W),
        .READ_LAT (READ_LAT),
        .MEM_BYTES(MEM_BYTES)
    ) dut (
        .CLk   (clk),
        .resetN(resetN),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem     [0:MEM_BYTES-1];
    logic [7:0]  ref_mem [0:MEM_BYTES-1];
    logic [31:0] apipe   [0:READ_LAT-1];
    int          wr_cycles = 0;
    int          n_checks  = 0;
    int          n_errors  = 0;
    vec_t        vecs [NV];

    function automatic logic [127:0] line_of(input bit use_ref, input logic [31:0] a);
        logic [127:0] l;
        logic [31:0]  ai;
        l = '0;
        for (int i = 0; i < 16; i++) begin
            ai = a + 32'(i);
            if (ai < 32'(MEM_BYTES))
                l[8*i +: 8] = use_ref ? ref_mem[ai[9:0]] : mem[ai[9:0]];
        end
        return l;
    endfunction

    // Memory: writes and address sampling on the falling edge; data valid only once the
    // address has been stable for READ_LAT falling edges, garbage before that.
    always @(negedge clk) begin
        logic stable;
        if (bus.memWriteMem) begin
            wr_cycles++;
            if (bus.memAddress <= 32'(MEM_BYTES - 4))
                for (int i = 0; i < 4; i++)
                    mem[10'(bus.memAddress + 32'(i))] = bus.memInputData[8*i +: 8];
        end
        for (int i = READ_LAT - 1; i > 0; i--) apipe[i] = apipe[i-1];
        apipe[0] = bus.memAddress;
        stable = 1'b1;
        for (int i = 1; i < READ_LAT; i++) if (apipe[i] !== apipe[0]) stable = 1'b0;
        bus.memData = stable ? line_of(1'b0, apipe[0]) : {4{32'hBAD0BAD0}};
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic ref_write(input logic [31:0] a, input logic [31:0] d);
        for (int i = 0; i < 4; i++) ref_mem[10'(a + 32'(i))] = d[8*i +: 8];
    endtask

    // One transaction on one port; returns latency in edges from the request being presented
    task automatic run_txn(input bit pb, input bit we, input logic [31:0] addr,
                           input logic [31:0] wd, output int lat, output bit err,
                           output logic [31:0] maddr, output logic [31:0] maddr_end,
                           output int wrs, output bit other, output bit done_after);
        int w_start;
        bit seen;
        w_start = wr_cycles;
        lat = 0; err = 1'b0; other = 1'b0; seen = 1'b0;
        maddr = '0; maddr_end = '0;
        if (pb) begin
            bus.reqB = 1'b1; bus.weB = we; bus.addrB = addr; bus.wdataB = wd;
        end else begin
            bus.reqA = 1'b1; bus.weA = we; bus.addrA = addr; bus.wdataA = wd;
        end
        while (!seen && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) maddr = bus.memAddress;
            if (pb ? bus.doneA : bus.doneB) other = 1'b1;
            if (pb ? bus.doneB : bus.doneA) begin
                seen      = 1'b1;
                err       = pb ? bus.errB : bus.errA;
                maddr_end = bus.memAddress;
            end
        end
        if (pb) bus.reqB = 1'b0; else bus.reqA = 1'b0;
        @(posedge clk); #1;
        done_after = bus.doneA | bus.doneB;
        wrs = wr_cycles - w_start;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          lat, wrs, t, ndone;
        bit          err, other, dafter, overlap;
        logic [31:0] maddr, maddr_end;
        int          who [4];
        int          tdone [4];
        logic [31:0] w0s [4];
        int          wr_before;
        bit          saw_done;

        vecs[0]  = '{1'b0, 1'b0, 32'h0000_0013, 32'h0,         1'b0, 32'h010, 5, 0, 32'h1312_1110, 32'h1F1E_1D1C};
        vecs[1]  = '{1'b1, 1'b1, 32'h0000_0023, 32'hDEAD_BEEF, 1'b0, 32'h020, 2, 1, 32'h1312_1110, 32'h1F1E_1D1C};
        vecs[2]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,         1'b0, 32'h020, 5, 0, 32'hDEAD_BEEF, 32'h2F2E_2D2C};
        vecs[3]  = '{1'b0, 1'b0, 32'h0000_03F4, 32'h0,         1'b0, 32'h3F0, 5, 0, 32'hF3F2_F1F0, 32'hFFFE_FDFC};
        vecs[4]  = '{1'b0, 1'b0, 32'h0000_0400, 32'h0,         1'b1, 32'h3F0, 1, 0, 32'hF3F2_F1F0, 32'hFFFE_FDFC};
        vecs[5]  = '{1'b1, 1'b1, 32'h0000_03FC, 32'h1122_3344, 1'b0, 32'h3FC, 2, 1, 32'hF3F2_F1F0, 32'hFFFE_FDFC};
        vecs[6]  = '{1'b1, 1'b1, 32'h0000_03FD, 32'h5566_7788, 1'b0, 32'h3FC, 2, 1, 32'hF3F2_F1F0, 32'hFFFE_FDFC};
        vecs[7]  = '{1'b1, 1'b1, 32'h0000_0400, 32'hAAAA_AAAA, 1'b1, 32'h3FC, 1, 0, 32'hF3F2_F1F0, 32'hFFFE_FDFC};
        vecs[8]  = '{1'b0, 1'b0, 32'h0000_03FF, 32'h0,         1'b0, 32'h3F0, 5, 0, 32'hF3F2_F1F0, 32'h5566_7788};
        vecs[9]  = '{1'b1, 1'b0, 32'h0000_03E9, 32'h0,         1'b0, 32'h3E0, 5, 0, 32'hE3E2_E1E0, 32'hEFEE_EDEC};
        vecs[10] = '{1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0,         1'b1, 32'h3E0, 1, 0, 32'hE3E2_E1E0, 32'hEFEE_EDEC};
        vecs[11] = '{1'b1, 1'b1, 32'h0000_03FB, 32'h0BAD_CAFE, 1'b0, 32'h3F8, 2, 1, 32'hE3E2_E1E0, 32'hEFEE_EDEC};
        vecs[12] = '{1'b0, 1'b1, 32'h0000_0403, 32'h7777_7777, 1'b1, 32'h3F8, 1, 0, 32'hE3E2_E1E0, 32'hEFEE_EDEC};
        vecs[13] = '{1'b0, 1'b0, 32'h0000_03F0, 32'h0,         1'b0, 32'h3F0, 5, 0, 32'hF3F2_F1F0, 32'h5566_7788};

        for (int i = 0; i < MEM_BYTES; i++) begin
            mem[i]     = 8'(i);
            ref_mem[i] = 8'(i);
        end
        clk = 1'b0; resetN = 1'b0;
        bus.reqA = 1'b0; bus.reqB = 1'b0; bus.weA = 1'b0; bus.weB = 1'b0;
        bus.addrA = '0; bus.addrB = '0; bus.wdataA = '0; bus.wdataB = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",  128'(bus.busy), 128'(0));
        check("rst_done",  128'({bus.doneA, bus.doneB, bus.errA, bus.errB}), 128'(0));
        check("rst_we",    128'(bus.memWriteMem), 128'(0));
        check("rst_maddr", 128'(bus.memAddress), 128'(0));
        check("rst_mdata", 128'(bus.memInputData), 128'(0));
        check("rst_rdata", bus.rdata, 128'(0));
        @(negedge clk); resetN = 1'b1;
        @(posedge clk); #1;

        // Single-port transaction table
        for (int k = 0; k < NV; k++) begin
            run_txn(vecs[k].pb, vecs[k].we, vecs[k].addr, vecs[k].wdata,
                    lat, err, maddr, maddr_end, wrs, other, dafter);
            if (vecs[k].we && !vecs[k].exp_err) ref_write(vecs[k].exp_maddr, vecs[k].wdata);
            check($sformatf("v%0d_lat", k),    128'(lat),       128'(vecs[k].exp_lat));
            check($sformatf("v%0d_err", k),    128'(err),       128'(vecs[k].exp_err));
            check($sformatf("v%0d_maddr", k),  128'(maddr),     128'(vecs[k].exp_maddr));
            check($sformatf("v%0d_mhold", k),  128'(maddr_end), 128'(vecs[k].exp_maddr));
            check($sformatf("v%0d_wrcyc", k),  128'(wrs),       128'(vecs[k].exp_wr));
            check($sformatf("v%0d_other", k),  128'(other),     128'(0));
            check($sformatf("v%0d_1cyc", k),   128'(dafter),    128'(0));
            check($sformatf("v%0d_w0", k),     128'(bus.rdata[31:0]),   128'(vecs[k].exp_w0));
            check($sformatf("v%0d_w3", k),     128'(bus.rdata[127:96]), 128'(vecs[k].exp_w3));
            if (!vecs[k].we && !vecs[k].exp_err)
                check($sformatf("v%0d_line", k), bus.rdata, line_of(1'b1, vecs[k].exp_maddr));
        end

        // B write in flight, A read arrives during WR and must wait for DONE+IDLE
        bus.reqB = 1'b1; bus.weB = 1'b1; bus.addrB = 32'h100; bus.wdataB = 32'hCAFE_F00D;
        @(posedge clk); #1;
        bus.reqA = 1'b1; bus.weA = 1'b0; bus.addrA = 32'h100;
        t = 1; ndone = 0; overlap = 1'b0;
        tdone[0] = -1; tdone[1] = -1;
        while (ndone < 2 && t < 40) begin
            @(posedge clk); #1; t++;
            if (bus.doneA && bus.doneB) overlap = 1'b1;
            if (bus.doneB) begin tdone[0] = t; bus.reqB = 1'b0; ndone++; end
            if (bus.doneA) begin tdone[1] = t; bus.reqA = 1'b0; ndone++; w0s[0] = bus.rdata[31:0]; end
        end
        ref_write(32'h100, 32'hCAFE_F00D);
        check("wait_doneB_t", 128'(tdone[0]), 128'(2));
        check("wait_doneA_t", 128'(tdone[1]), 128'(8));
        check("wait_overlap", 128'(overlap), 128'(0));
        check("wait_rdata",   128'(w0s[0]), 128'(32'hCAFE_F00D));
        @(posedge clk); #1;

        // Reset two cycles into a read: everything clears at once, no done
        bus.reqA = 1'b1; bus.weA = 1'b0; bus.addrA = 32'h40;
        @(posedge clk); @(posedge clk); #2;
        resetN = 1'b0; #1;
        check("rrd_busy",  128'(bus.busy), 128'(0));
        check("rrd_maddr", 128'(bus.memAddress), 128'(0));
        check("rrd_rdata", bus.rdata, 128'(0));
        check("rrd_done",  128'({bus.doneA, bus.errA}), 128'(0));
        bus.reqA = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (bus.doneA || bus.doneB) saw_done = 1'b1;
        end
        @(negedge clk); resetN = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.doneA || bus.doneB) saw_done = 1'b1;
        end
        check("rrd_nodone", 128'(saw_done), 128'(0));
        run_txn(1'b0, 1'b0, 32'h47, 32'h0, lat, err, maddr, maddr_end, wrs, other, dafter);
        check("rrd_fresh_lat",   128'(lat), 128'(5));
        check("rrd_fresh_maddr", 128'(maddr), 128'(32'h40));
        check("rrd_fresh_w0",    128'(bus.rdata[31:0]), 128'(32'h4342_4140));

        // Reset inside the WR cycle: write strobe drops immediately, memory untouched
        wr_before = wr_cycles;
        bus.reqB = 1'b1; bus.weB = 1'b1; bus.addrB = 32'h80; bus.wdataB = 32'h1234_5678;
        @(posedge clk); #2;
        check("rwr_we_on", 128'(bus.memWriteMem), 128'(1));
        resetN = 1'b0; #1;
        check("rwr_we_off", 128'(bus.memWriteMem), 128'(0));
        check("rwr_mdata",  128'(bus.memInputData), 128'(0));
        bus.reqB = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); resetN = 1'b1;
        check("rwr_nowrite", 128'(wr_cycles - wr_before), 128'(0));
        run_txn(1'b1, 1'b0, 32'h80, 32'h0, lat, err, maddr, maddr_end, wrs, other, dafter);
        check("rwr_read_w0", 128'(bus.rdata[31:0]), 128'(32'h8382_8180));

        // Fresh reset, then both ports hold read requests: A,B,A,B with fixed spacing
        @(negedge clk); resetN = 1'b0;
        @(negedge clk); resetN = 1'b1;
        bus.reqA = 1'b1; bus.weA = 1'b0; bus.addrA = 32'h00;
        bus.reqB = 1'b1; bus.weB = 1'b0; bus.addrB = 32'h10;
        for (int i = 0; i < 4; i++) begin who[i] = -1; tdone[i] = -1; w0s[i] = '0; end
        t = 0; ndone = 0; overlap = 1'b0;
        while (ndone < 4 && t < 80) begin
            @(posedge clk); #1; t++;
            if (bus.doneA && bus.doneB) overlap = 1'b1;
            if (bus.doneA || bus.doneB) begin
                who[ndone]   = bus.doneB ? 1 : 0;
                tdone[ndone] = t;
                w0s[ndone]   = bus.rdata[31:0];
                ndone++;
            end
        end
        bus.reqA = 1'b0; bus.reqB = 1'b0;
        @(posedge clk); #1;
        check("rr_count",   128'(ndone), 128'(4));
        check("rr_overlap", 128'(overlap), 128'(0));
        check("rr_first_t", 128'(tdone[0]), 128'(5));
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rr_who%0d", i), 128'(who[i]), 128'(i % 2));
            check($sformatf("rr_w0_%0d", i), 128'(w0s[i]),
                  128'((i % 2 == 0) ? 32'h0302_0100 : 32'h1312_1110));
            if (i > 0) check($sformatf("rr_gap%0d", i), 128'(tdone[i] - tdone[i-1]), 128'(6));
        end
        check("rr_idle_busy", 128'(bus.busy), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
